// File: rtl/lock_ctrl_if.sv
// ---------------------------------------------------------------------------
// lock_ctrl_if
//   Groups the keypad, detector and status signals of the lock sequencing
//   controller into one bundle.
//
//   Parameter
//     FW         width of fail_cnt, $clog2(MAX_FAILS+1) of the controller
//
//   Signals
//     key_valid  keypad -> ctrl   key_bit valid this cycle
//     key_bit    keypad -> ctrl   serial code bit
//     det_match  det    -> ctrl   detector registered match output
//     det_en     ctrl   -> det    detector samples det_in only when high
//     det_in     ctrl   -> det    bit forwarded to detector
//     det_clr    ctrl   -> det    one-cycle detector state clear
//     unlock     ctrl   -> env    lock release
//     alarm      ctrl   -> env    lockout alarm
//     fail_cnt   ctrl   -> env    consecutive failed attempts
//     busy       ctrl   -> env    high whenever not accepting key bits
//
//   Modports
//     master     environment side (keypad + detector)
//     slave      the controller
// ---------------------------------------------------------------------------
interface lock_ctrl_if #(
    parameter int FW = 2
);
    logic          key_valid;
    logic          key_bit;
    logic          det_match;
    logic          det_en;
    logic          det_in;
    logic          det_clr;
    logic          unlock;
    logic          alarm;
    logic [FW-1:0] fail_cnt;
    logic          busy;

    modport master (
        output key_valid, key_bit, det_match,
        input  det_en, det_in, det_clr, unlock, alarm, fail_cnt, busy
    );

    modport slave (
        input  key_valid, key_bit, det_match,
        output det_en, det_in, det_clr, unlock, alarm, fail_cnt, busy
    );
endinterface

// File: rtl/lock_ctrl.sv
// ---------------------------------------------------------------------------
// lock_ctrl
//   Sequencing controller for the electronic lock's serial code detector.
//   Key bits are framed into attempts of CODE_LEN bits and gated into the
//   detector one cycle after they are accepted. Two cycles after the last bit
//   of an attempt the detector's registered match is sampled: a match opens
//   the lock for UNLOCK_CYCLES, a miss bumps the failure counter, and
//   MAX_FAILS consecutive misses raise the alarm for LOCKOUT_CYCLES. Each
//   return to ENTRY clears the detector with a one-cycle det_clr pulse.
//
//   Ports
//     clk   in   rising-edge clock
//     rst   in   synchronous, active-high reset
//     bus   lock_ctrl_if.slave (key_valid, key_bit, det_match in;
//           det_en, det_in, det_clr, unlock, alarm, fail_cnt, busy out)
//
//   Optional feature (macro LOCK_CTRL_TIMEOUT_EN)
//     When defined, a partial attempt left idle for ENTRY_TIMEOUT cycles is
//     discarded and the detector cleared; it is not counted as a failure.
//     When undefined, a partial attempt waits indefinitely.
// ---------------------------------------------------------------------------
module lock_ctrl #(
    parameter int CODE_LEN       = 5,
    parameter int MAX_FAILS      = 3,
    parameter int UNLOCK_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES = 20,
    parameter int ENTRY_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    lock_ctrl_if.slave  bus
);

    localparam int FW    = $clog2(MAX_FAILS + 1);
    localparam int BW    = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    // One timer serves the unlock hold, the lockout hold and the entry timeout.
    localparam int TMAX0 = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMAX  = (TMAX0 > ENTRY_TIMEOUT) ? TMAX0 : ENTRY_TIMEOUT;
    localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [BW-1:0] LAST_BIT     = BW'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_LAST    = FW'(MAX_FAILS - 1);
    localparam logic [FW-1:0] FAIL_MAX     = FW'(MAX_FAILS);
    localparam logic [TW-1:0] UNLOCK_LAST  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
`ifdef LOCK_CTRL_TIMEOUT_EN
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ENTRY_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        CHECK1  = 3'd1,
        CHECK2  = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    state_t        state_q,    state_d;
    logic [BW-1:0] bit_cnt_q,  bit_cnt_d;
    logic [TW-1:0] tmr_q,      tmr_d;
    logic [FW-1:0] fail_cnt_q, fail_cnt_d;
    logic          det_en_q,   det_en_d;
    logic          det_in_q,   det_in_d;
    logic          det_clr_q,  det_clr_d;
    logic          unlock_q,   unlock_d;
    logic          alarm_q,    alarm_d;
    logic          busy_q,     busy_d;
    logic          abort_clr;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tmr_d      = tmr_q;
        fail_cnt_d = fail_cnt_q;
        det_en_d   = 1'b0;
        det_in_d   = det_in_q;
        abort_clr  = 1'b0;

        case (state_q)
            ENTRY: begin
                if (bus.key_valid) begin
                    det_en_d = 1'b1;
                    det_in_d = bus.key_bit;
                    tmr_d    = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = CHECK1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
`ifdef LOCK_CTRL_TIMEOUT_EN
                // Idle cycles are counted only while a partial attempt is held.
                else if (bit_cnt_q != '0) begin
                    if (tmr_q == TIMEOUT_LAST) begin
                        bit_cnt_d = '0;
                        tmr_d     = '0;
                        abort_clr = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
`endif
            end

            // Detector registers the final bit during this cycle.
            CHECK1: state_d = CHECK2;

            CHECK2: begin
                tmr_d = '0;
                if (bus.det_match) begin
                    fail_cnt_d = '0;
                    state_d    = OPEN;
                end else if (fail_cnt_q == FAIL_LAST) begin
                    fail_cnt_d = FAIL_MAX;
                    state_d    = LOCKOUT;
                end else begin
                    fail_cnt_d = fail_cnt_q + FW'(1);
                    state_d    = ENTRY;
                end
            end

            OPEN: begin
                if (tmr_q == UNLOCK_LAST) begin
                    tmr_d   = '0;
                    state_d = ENTRY;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end

            LOCKOUT: begin
                if (tmr_q == LOCKOUT_LAST) begin
                    tmr_d      = '0;
                    fail_cnt_d = '0;
                    state_d    = ENTRY;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end

            default: state_d = ENTRY;
        endcase

        // Outputs are registered from the next state so that they line up
        // with the state they describe.
        det_clr_d = ((state_d == ENTRY) && (state_q != ENTRY)) || abort_clr;
        unlock_d  = (state_d == OPEN);
        alarm_d   = (state_d == LOCKOUT);
        busy_d    = (state_d != ENTRY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ENTRY;
            bit_cnt_q  <= '0;
            tmr_q      <= '0;
            fail_cnt_q <= '0;
            det_en_q   <= 1'b0;
            det_in_q   <= 1'b0;
            det_clr_q  <= 1'b0;
            unlock_q   <= 1'b0;
            alarm_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tmr_q      <= tmr_d;
            fail_cnt_q <= fail_cnt_d;
            det_en_q   <= det_en_d;
            det_in_q   <= det_in_d;
            det_clr_q  <= det_clr_d;
            unlock_q   <= unlock_d;
            alarm_q    <= alarm_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.det_en   = det_en_q;
    assign bus.det_in   = det_in_q;
    assign bus.det_clr  = det_clr_q;
    assign bus.unlock   = unlock_q;
    assign bus.alarm    = alarm_q;
    assign bus.fail_cnt = fail_cnt_q;
    assign bus.busy     = busy_q;

endmodule
